// File: rtl/clmul_div_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clmul_div_8bit                                               |
// | Description : Bit-serial carry-less (GF(2)[x]) polynomial divider, 2W-bit   |
// |               dividend by W-bit divisor, valid/ready on both sides.         |
// |               Optional result self-check: CLMUL_DIV_SELFCHECK_EN.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module clmul_div_8bit #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             div_zero,
    output logic             chk_err
);
    localparam int c_QW = 2 * W;
    localparam int c_CW = $clog2(c_QW);
    localparam int c_DW = $clog2(W);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_QW-1:0] r_n;
    logic [W-1:0]    r_d;
    logic [c_QW-1:0] r_q;
    logic [W-1:0]    r_p;
    logic [c_CW-1:0] r_cnt;
    logic [c_DW-1:0] r_dg;
    logic            r_dz;

    logic [c_DW-1:0] w_dg;
    logic [W-1:0]    w_t;
    logic            w_hit;
    logic [W-1:0]    w_p_next;
    logic [c_QW-1:0] w_q_next;
    logic            w_chk;

    // Divisor degree: position of the highest set bit
    always_comb begin
        w_dg = '0;
        for (int i = 0; i < W; i++) begin
            if (divisor[i]) begin
                w_dg = c_DW'(i);
            end
        end
    end

    // deg P < dg <= W-1, so the top bit of P is always clear and the shifted
    // value still fits in W bits.
    assign w_t      = {r_p[W-2:0], r_n[r_cnt]};
    assign w_hit    = w_t[r_dg];
    assign w_p_next = w_hit ? (w_t ^ r_d) : w_t;
    assign w_q_next = {r_q[c_QW-2:0], w_hit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_state_next = (divisor == '0) ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        quotient  = (r_state == c_DONE) ? r_q : '0;
        remainder = (r_state == c_DONE) ? r_p : '0;
        div_zero  = (r_state == c_DONE) && r_dz;
        chk_err   = (r_state == c_DONE) && w_chk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n   <= '0;
            r_d   <= '0;
            r_q   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_dg  <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_n   <= dividend;
                        r_d   <= divisor;
                        r_q   <= '0;
                        r_p   <= '0;
                        r_dg  <= w_dg;
                        r_cnt <= c_CW'(c_QW - 1);
                        r_dz  <= (divisor == '0);
                    end
                end
                c_CALC: begin
                    r_q <= w_q_next;
                    r_p <= w_p_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CLMUL_DIV_SELFCHECK_EN
    logic [c_QW-1:0] w_prod;
    logic            r_chk;

    // Rebuild Q*D ^ R from the final-step values so the check lands with DONE
    always_comb begin
        w_prod = {{W{1'b0}}, w_p_next};
        for (int i = 0; i < W; i++) begin
            if (r_d[i]) begin
                w_prod = w_prod ^ (w_q_next << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= 1'b0;
        end else if (r_state == c_IDLE) begin
            r_chk <= 1'b0;
        end else if ((r_state == c_CALC) && (r_cnt == '0)) begin
            r_chk <= (w_prod != r_n);
        end
    end

    assign w_chk = r_chk;
`else
    assign w_chk = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clmul_div_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clmul_div_8bit                                            |
// | Description : Self-checking bench for clmul_div_8bit: vector table, random  |
// |               operands against a polynomial long-division model, corners.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_clmul_div_8bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        chk_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } res_t;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } vec_t;

    clmul_div_8bit #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "timeout");
    end

    // Schoolbook polynomial long division over GF(2)
    function automatic res_t ref_div(input logic [15:0] n, input logic [7:0] d);
        res_t        res;
        logic [15:0] rem;
        int          dd;
        res = '0;
        if (d == 8'h00) begin
            res.dz = 1'b1;
            return res;
        end
        dd = 0;
        for (int i = 0; i < 8; i++) if (d[i]) dd = i;
        rem = n;
        for (int s = 15 - dd; s >= 0; s--) begin
            if (rem[s + dd]) begin
                res.q[s] = 1'b1;
                rem = rem ^ ({8'h00, d} << s);
            end
        end
        res.r = rem[7:0];
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] n, input logic [7:0] d);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input res_t exp, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_out_valid"}, out_valid, 1);
        check({name, "_quotient"}, quotient, exp.q);
        check({name, "_remainder"}, remainder, exp.r);
        check({name, "_div_zero"}, div_zero, exp.dz);
        check({name, "_chk_err"}, chk_err, 0);
        check({name, "_in_ready_busy"}, in_ready, 0);
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_out_valid_after"}, out_valid, 0);
        check({name, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        vec_t        vecs[6];
        res_t        exp;
        logic [15:0] n;
        logic [7:0]  d;

        vecs[0] = '{n: 16'h2B79, d: 8'h83, q: 16'h0057, r: 8'h00, dz: 1'b0, lat: 17};
        vecs[1] = '{n: 16'h2B7A, d: 8'h83, q: 16'h0057, r: 8'h03, dz: 1'b0, lat: 17};
        vecs[2] = '{n: 16'hBEEF, d: 8'h01, q: 16'hBEEF, r: 8'h00, dz: 1'b0, lat: 17};
        vecs[3] = '{n: 16'h0005, d: 8'h80, q: 16'h0000, r: 8'h05, dz: 1'b0, lat: 17};
        vecs[4] = '{n: 16'h1234, d: 8'h00, q: 16'h0000, r: 8'h00, dz: 1'b1, lat: 1};
        vecs[5] = '{n: 16'h0000, d: 8'h13, q: 16'h0000, r: 8'h00, dz: 1'b0, lat: 17};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_chk_err", chk_err, 0);

        for (int i = 0; i < 6; i++) begin
            exp = '{q: vecs[i].q, r: vecs[i].r, dz: vecs[i].dz};
            send(vecs[i].n, vecs[i].d);
            collect($sformatf("vec%0d", i), exp, vecs[i].lat);
            release_result($sformatf("vec%0d", i));
        end

        for (int k = 0; k < 30; k++) begin
            n = 16'($urandom);
            d = 8'($urandom);
            if (k % 9 == 0) d = 8'h00;
            else if (k % 5 == 0) d = 8'($urandom_range(1, 7));
            exp = ref_div(n, d);
            send(n, d);
            collect($sformatf("rand%0d", k), exp, (d == 8'h00) ? 1 : 17);
            release_result($sformatf("rand%0d", k));
        end

        // Backpressure in DONE with stray in_valid pulses
        send(16'h2B7A, 8'h83);
        collect("bp", ref_div(16'h2B7A, 8'h83), 17);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            dividend = 16'hFFFF;
            divisor  = 8'h01;
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_quotient", quotient, 16'h0057);
            check("bp_hold_remainder", remainder, 8'h03);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b1;
        dividend = 16'hA5C3;
        divisor  = 8'h1B;
        release_result("bp");
        send(16'hA5C3, 8'h1B);
        collect("bp_next", ref_div(16'hA5C3, 8'h1B), 17);
        release_result("bp_next");

        // Reset in the middle of a division
        send(16'h2B79, 8'h83);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_zero", div_zero, 0);
        begin
            int seen = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("midrst_no_stale_result", seen, 0);
        end
        send(16'h2B7A, 8'h83);
        collect("midrst_fresh", ref_div(16'h2B7A, 8'h83), 17);
        release_result("midrst_fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
